dfp_arbiter: RTL
================

DFP_ARBITER -- requirements
Module: dfp_arbiter

Interface
REQ-001 SHALL have parameter LINE_BITS, default 256: cache line / memory data width.
REQ-002 SHALL have parameter ADDR_BITS, default 32: byte address width.
REQ-003 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have ports c0_addr/c1_addr, input, ADDR_BITS: line address from requester 0 (icache) / 1 (dcache).
REQ-006 SHALL have ports c0_read/c1_read and c0_write/c1_write, input, 1 each: line read / writeback request, held until own resp.
REQ-007 SHALL have ports c0_wdata/c1_wdata, input, LINE_BITS: writeback data.
REQ-008 SHALL have ports c0_rdata/c1_rdata, output, LINE_BITS: fill data, valid when own resp is high.
REQ-009 SHALL have ports c0_resp/c1_resp, output, 1: one-cycle completion pulse.
REQ-010 SHALL have ports dfp_addr (ADDR_BITS), dfp_read (1), dfp_write (1), dfp_wdata (LINE_BITS), all outputs, to memory.
REQ-011 SHALL have ports dfp_rdata (LINE_BITS) and dfp_resp (1), inputs, from memory.
REQ-012 SHALL have outputs perf_gnt0, perf_gnt1, perf_conflict, 32 bits each: performance counters.

Function
REQ-013 SHALL implement FSM states IDLE, GNT0, GNT1; reqN = cN_read | cN_write.
REQ-014 In IDLE with only reqN high, SHALL go to GNTN next cycle.
REQ-015 In IDLE with both requests high, SHALL grant the requester not granted last (round-robin pointer); after reset, requester 0 wins.
REQ-016 On grant, SHALL latch the granted requester's addr, read, write, wdata; dfp outputs SHALL be driven only from these registers while in GNTN.
REQ-017 Grant-to-dfp latency SHALL be 1 cycle: dfp_read/dfp_write high in the first GNTN cycle.
REQ-018 Latched request SHALL be held unchanged until dfp_resp, regardless of requester input changes.
REQ-019 On dfp_resp in GNTN, SHALL assert cN_resp the same cycle with cN_rdata = dfp_rdata, update pointer to N, and return to IDLE.
REQ-020 The other requester's resp SHALL stay low; cN_rdata of the non-responding requester SHALL be don't-care.
REQ-021 After each completion, SHALL spend one IDLE cycle (arbitration bubble) before the next grant.
REQ-022 dfp_resp in IDLE SHALL be ignored: no resp pulse, no state change.
REQ-023 Requesters SHALL deassert or change requests in the cycle after resp; any request seen in IDLE is a new transaction.
REQ-024 Read and write both high from one requester SHALL be forwarded as latched; this is a requester protocol violation flagged by bench assertion.
REQ-025 Max dfp utilisation SHALL be one transaction per (memory latency + 2) cycles.

Reset
REQ-026 While rst is low: state IDLE, pointer favours requester 0, dfp_read/dfp_write/c0_resp/c1_resp low, latched addr/wdata zero, perf counters zero.
REQ-027 Reset asserted mid-transaction SHALL abandon it immediately; a late dfp_resp arrives in IDLE and is ignored per REQ-022.

Configuration
REQ-028 Macro DFP_ARB_PERF_EN defined: perf_gnt0/perf_gnt1 SHALL increment on each grant to that requester; perf_conflict SHALL increment on each IDLE cycle with both requests high; all saturate at 0xFFFFFFFF.
REQ-029 Macro DFP_ARB_PERF_EN undefined: perf outputs SHALL be constant zero and no counter flops SHALL exist; ports remain.

Structure
REQ-030 arb_state_t enum (IDLE, GNT0, GNT1) SHALL live in shared package mutative_types.
REQ-031 Round-robin pointer and grant decision SHALL be sub-module dfp_rr_pick (inputs req0, req1, last; output winner); all else in dfp_arbiter.

Verification
REQ-032 c0_read only, addr 0x0000_1000, memory resp after 5 cycles with rdata 0xA5..A5 -> dfp_read high cycle 1, c0_resp pulse cycle 6 with that data, c1_resp low.
REQ-033 c0_read and c1_write same cycle after reset -> requester 0 served first, then bubble, then c1 write with c1_wdata on dfp_wdata; perf_conflict = 1 (macro on).
REQ-034 Both requesting continuously for 6 transactions -> grants alternate 0,1,0,1,0,1; perf_gnt0 = perf_gnt1 = 3.
REQ-035 c1 changes addr 0x40 -> 0x80 mid-grant -> dfp_addr stays 0x40 until dfp_resp.
REQ-036 rst low during GNT1, then dfp_resp in following IDLE -> no resp pulse, dfp_read low, state IDLE.
REQ-037 Build without DFP_ARB_PERF_EN, repeat REQ-034 -> identical grant order, perf outputs all zero.

Source files
------------

// File: rtl/mutative_types.sv
// Shared arbiter types: grant FSM encoding and saturating counter helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mutative_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam logic [31:0] PERF_MAX = 32'hFFFF_FFFF;

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == PERF_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dfp_rr_pick.sv
// Round-robin grant decision between the icache (0) and dcache (1) requesters.
// Latency: combinational.
// Backpressure: none; the caller only samples winner while idle.
module dfp_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner
);

  // Lone requester wins outright; on contention the side not served last wins.
  always_comb begin
    winner = 1'b0;
    if (req0 && req1) begin
      winner = ~last;
    end else if (req1) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/dfp_arbiter.sv
// Two-requester line arbiter in front of a single memory port; optional perf counters (DFP_ARB_PERF_EN).
// Latency: grant one cycle after request seen in IDLE, resp same cycle as dfp_resp, one IDLE bubble after each completion.
// Backpressure: requesters hold read/write until their resp pulse; one transaction outstanding at a time.
module dfp_arbiter
  import mutative_types::*;
#(
  parameter int LINE_BITS = 256,
  parameter int ADDR_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] c0_addr,
  input  logic                 c0_read,
  input  logic                 c0_write,
  input  logic [LINE_BITS-1:0] c0_wdata,
  output logic [LINE_BITS-1:0] c0_rdata,
  output logic                 c0_resp,
  input  logic [ADDR_BITS-1:0] c1_addr,
  input  logic                 c1_read,
  input  logic                 c1_write,
  input  logic [LINE_BITS-1:0] c1_wdata,
  output logic [LINE_BITS-1:0] c1_rdata,
  output logic                 c1_resp,
  output logic [ADDR_BITS-1:0] dfp_addr,
  output logic                 dfp_read,
  output logic                 dfp_write,
  output logic [LINE_BITS-1:0] dfp_wdata,
  input  logic [LINE_BITS-1:0] dfp_rdata,
  input  logic                 dfp_resp,
  output logic [31:0]          perf_gnt0,
  output logic [31:0]          perf_gnt1,
  output logic [31:0]          perf_conflict
);

  arb_state_t             state;
  logic                   last;      // 1 when requester 1 completed most recently
  logic                   req0;
  logic                   req1;
  logic                   winner;
  logic [ADDR_BITS-1:0]   lat_addr;
  logic                   lat_read;
  logic                   lat_write;
  logic [LINE_BITS-1:0]   lat_wdata;

  assign req0 = c0_read | c0_write;
  assign req1 = c1_read | c1_write;

  dfp_rr_pick u_pick (
    .req0   (req0),
    .req1   (req1),
    .last   (last),
    .winner (winner)
  );

  // Grant FSM: latch the winner's request in IDLE, hold it until memory answers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      lat_addr  <= '0;
      lat_read  <= 1'b0;
      lat_write <= 1'b0;
      lat_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state     <= winner ? GNT1 : GNT0;
            lat_addr  <= winner ? c1_addr  : c0_addr;
            lat_read  <= winner ? c1_read  : c0_read;
            lat_write <= winner ? c1_write : c0_write;
            lat_wdata <= winner ? c1_wdata : c0_wdata;
          end
        end
        GNT0, GNT1: begin
          if (dfp_resp) begin
            state     <= IDLE;
            last      <= (state == GNT1);
            lat_read  <= 1'b0;
            lat_write <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory side comes straight from the latched copy, so requester churn never leaks through.
  assign dfp_addr  = lat_addr;
  assign dfp_read  = lat_read;
  assign dfp_write = lat_write;
  assign dfp_wdata = lat_wdata;

  // Completion is forwarded in the same cycle as the memory response.
  assign c0_resp  = (state == GNT0) && dfp_resp;
  assign c1_resp  = (state == GNT1) && dfp_resp;
  assign c0_rdata = dfp_rdata;
  assign c1_rdata = dfp_rdata;

`ifdef DFP_ARB_PERF_EN
  logic [31:0] gnt0_q;
  logic [31:0] gnt1_q;
  logic [31:0] conf_q;

  // Count grants per requester and contended arbitration cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt0_q <= '0;
      gnt1_q <= '0;
      conf_q <= '0;
    end else if (state == IDLE) begin
      if (req0 && req1) begin
        conf_q <= sat_inc(conf_q);
      end
      if (req0 || req1) begin
        if (winner) begin
          gnt1_q <= sat_inc(gnt1_q);
        end else begin
          gnt0_q <= sat_inc(gnt0_q);
        end
      end
    end
  end

  assign perf_gnt0     = gnt0_q;
  assign perf_gnt1     = gnt1_q;
  assign perf_conflict = conf_q;
`else
  assign perf_gnt0     = '0;
  assign perf_gnt1     = '0;
  assign perf_conflict = '0;
`endif

endmodule
